exc_ctrl: RTL
=============

# exc_ctrl

Parametrised exception sequencer for the LEGv8 single-issue core, sitting beside the main decoder in the decode stage. It consumes the decoder's `NotAnInstr`/`ERet` flags plus N external interrupt lines, and arbitrates invalid-opcode and IRQ exceptions. It saves the return PC (ELR) and the cause (`EStatus`, IRQ index), and drives pipeline flush and PC redirect. It sequences entry to the handler, residence in it, and the ERET return.

## Interface
Parameters:
- `N_IRQ`, 4: number of external IRQ lines; legal range 2..16.
- `PC_W`, 64: PC/ELR width.
- `VEC_ADDR`, `64'h0000_0000_0000_00D8`: exception vector, truncated to `PC_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `instr_valid` in 1: decode-stage instruction is valid this cycle.
- `pc_in` in `PC_W`: PC of the decode-stage instruction.
- `NotAnInstr` in 1: decoder flags an invalid opcode.
- `ERet` in 1: decoder flags ERET.
- `irq` in `N_IRQ`: external interrupt requests, level.
- `exc_taken` out 1: one-cycle pulse on exception entry.
- `flush` out 1: squash the decode-stage instruction and younger instructions.
- `redirect_valid` out 1: fetch loads `redirect_pc` this cycle.
- `redirect_pc` out `PC_W`: redirect target.
- `ELR` out `PC_W`: saved return PC.
- `EStatus` out 4: exception cause.
- `irq_id` out `$clog2(N_IRQ)`: index of the IRQ taken.
- `in_handler` out 1: high in HANDLER.
- `dbl_fault` out 1: sticky; set by an invalid opcode inside the handler.

## Operation
- States: RUN, ENTER, HANDLER, RETURN.
- Reset values: state RUN, `ELR`=0, `EStatus`=0, `irq_id`=0, pending=0, `dbl_fault`=0, all pulse outputs 0.
- `EStatus` encoding: 0000 none, 0001 external IRQ, 0010 invalid opcode. Other codes are never produced.

**RUN**
- With `instr_valid`:
  - `NotAnInstr` → go to ENTER; `EStatus`=0010; `ELR`=`pc_in`.
  - Otherwise, if any pending bit is set → go to ENTER; `EStatus`=0001; `irq_id`=lowest set pending index; `ELR`=`pc_in` (the preempted instruction re-executes); clear that pending bit.
- Without `instr_valid`: no exception is taken; pending bits hold.
- `ERet` in RUN is ignored: no redirect, no state change.

**ENTER** (exactly one cycle)
- Drives `exc_taken`=1, `flush`=1, `redirect_valid`=1, `redirect_pc`=`VEC_ADDR`.
- Then goes to HANDLER.

**HANDLER**
- `in_handler`=1. IRQs are not taken; pending bits keep accumulating.
- `instr_valid`&`NotAnInstr` → set `dbl_fault`; state, `ELR` and `EStatus` are unchanged.
- `instr_valid`&`ERet` → go to RETURN.

**RETURN** (exactly one cycle)
- Drives `flush`=1, `redirect_valid`=1, `redirect_pc`=`ELR`; clears `EStatus` to 0.
- Then goes to RUN.
- A pending IRQ may be taken on the first valid instruction in RUN. This is the earliest cycle after the return.

**General rules**
- `NotAnInstr` and `ERet` both high: `NotAnInstr` wins.
- Invalid opcode with an IRQ pending in the same cycle: invalid opcode wins; the IRQ stays pending.
- `reset` asserted mid-sequence forces RUN immediately and clears every register, including pending and `dbl_fault`.

## Timing
- Exception detection happens in cycle t, combinationally from registered state plus inputs.
- ENTER is registered and visible in t+1; HANDLER starts in t+2.
- ERET seen in cycle t → RETURN outputs in t+1 → RUN in t+2.
- `exc_taken`, `flush` and `redirect_valid` are registered outputs, high for exactly one cycle per event.
- `ELR`, `EStatus` and `irq_id` update at the t→t+1 edge and hold until the next entry or return.

## Configuration
`EXC_IRQ_EDGE_EN` controls how the pending register is fed.
- Defined:
  - A pending bit sets on a rising edge of `irq[i]`, detected against a registered copy `irq_q`.
  - It stays set after `irq` drops, until that IRQ is taken.
  - A set and a clear of the same bit in the same cycle resolve to set.
- Undefined:
  - Pending equals the live `irq` level; there is no `irq_q` and no stickiness.
  - An IRQ deasserted before a valid RUN instruction is lost.

## Test plan
- Reset release, then RUN with `Op` valid, `NotAnInstr`=0, `irq`=0 → all outputs stay 0 and `in_handler`=0.
- `pc_in`=0x40, `NotAnInstr`=1 → next cycle `exc_taken`=`flush`=`redirect_valid`=1, `redirect_pc`=0xD8, `ELR`=0x40, `EStatus`=0010; cycle after that `in_handler`=1.
- `irq`=4'b1010 in RUN with `pc_in`=0x80 → `EStatus`=0001, `irq_id`=1, `ELR`=0x80. ERET in the handler → `redirect_pc`=0x80. IRQ3 is then taken on the next valid instruction with `irq_id`=3.
- `NotAnInstr`=1 and `irq[0]`=1 in the same cycle, `pc_in`=0x10 → `EStatus`=0010. After ERET, IRQ0 is taken with `ELR`=the `pc_in` of that instruction.
- `NotAnInstr` inside HANDLER → `dbl_fault`=1 and no redirect. `reset` asserted during ENTER → all outputs 0 immediately, state RUN.
- With `EXC_IRQ_EDGE_EN`: a 1-cycle `irq[2]` pulse during HANDLER is taken after ERET with `irq_id`=2. Without the macro, the same pulse is lost.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception sequencer for the LEGv8 decode stage: invalid-opcode and IRQ entry, handler residence, ERET return.
// Optional build macro EXC_IRQ_EDGE_EN: sticky, rising-edge pending IRQs (default: pending follows live irq level).
module exc_ctrl #(
  parameter int          N_IRQ    = 4,
  parameter int          PC_W     = 64,
  parameter logic [63:0] VEC_ADDR = 64'h0000_0000_0000_00D8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_valid,
  input  logic [PC_W-1:0]            pc_in,
  input  logic                       NotAnInstr,
  input  logic                       ERet,
  input  logic [N_IRQ-1:0]           irq,
  output logic                       exc_taken,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [PC_W-1:0]            redirect_pc,
  output logic [PC_W-1:0]            ELR,
  output logic [3:0]                 EStatus,
  output logic [$clog2(N_IRQ)-1:0]   irq_id,
  output logic                       in_handler,
  output logic                       dbl_fault
);

  // state   | meaning
  // RUN     | normal execution, exceptions may be taken
  // ENTER   | one-cycle flush + redirect to the vector
  // HANDLER | executing the handler, IRQs masked
  // RETURN  | one-cycle flush + redirect to ELR
  typedef enum logic [1:0] {RUN, ENTER, HANDLER, RETURN} state_t;

  localparam int             IW  = $clog2(N_IRQ);
  localparam logic [PC_W-1:0] VEC = PC_W'(VEC_ADDR);

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] pending;
  logic [IW-1:0]    irq_sel;
  logic             take_nai, take_irq, take_eret, set_dbl;

  // lowest set pending index wins
  always_comb begin
    irq_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) irq_sel = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // outputs decode only the registered state, so they behave as registered pulses
  always_comb begin
    state_nxt      = state;
    take_nai       = 1'b0;
    take_irq       = 1'b0;
    take_eret      = 1'b0;
    set_dbl        = 1'b0;
    exc_taken      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    in_handler     = 1'b0;
    case (state)
      RUN: begin
        if (instr_valid) begin
          if (NotAnInstr) begin
            take_nai  = 1'b1;
            state_nxt = ENTER;
          end else if (|pending) begin
            take_irq  = 1'b1;
            state_nxt = ENTER;
          end
        end
      end
      ENTER: begin
        exc_taken      = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = VEC;
        state_nxt      = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        if (instr_valid) begin
          if (NotAnInstr) begin
            set_dbl = 1'b1;
          end else if (ERet) begin
            take_eret = 1'b1;
            state_nxt = RETURN;
          end
        end
      end
      RETURN: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = ELR;
        state_nxt      = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ELR       <= '0;
      EStatus   <= 4'b0000;
      irq_id    <= '0;
      dbl_fault <= 1'b0;
    end else begin
      if (take_nai) begin
        ELR     <= pc_in;
        EStatus <= 4'b0010;
      end else if (take_irq) begin
        ELR     <= pc_in;
        EStatus <= 4'b0001;
        irq_id  <= irq_sel;
      end else if (take_eret) begin
        EStatus <= 4'b0000;
      end
      if (set_dbl) dbl_fault <= 1'b1;
    end
  end

`ifdef EXC_IRQ_EDGE_EN
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending_clr;

  always_comb begin
    pending_clr = '0;
    if (take_irq) pending_clr = N_IRQ'(1) << irq_sel;
  end

  // a new edge on the bit being taken re-arms it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~pending_clr) | (irq & ~irq_q);
    end
  end
`else
  assign pending = irq;
`endif

endmodule
